// File: rtl/kf_frame_loader.sv
// kf_frame_loader
// Host-side frame loader for the Kalman filter core. Measurement words arriving
// on a valid/ready stream are written to consecutive data-bank addresses. The
// loader then pulses START, waits for READY to fall and rise again, captures
// DATA_OUT and offers it on an output valid/ready stream. A watchdog abandons
// runs that never complete and raises a sticky error flag.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_data/in_ready     measurement stream (in_ready is combinational)
//   out_valid/out_data/out_ready  estimate stream
//   kf_ready, kf_data_out    core READY and DATA_OUT
//   kf_start, kf_data_in, kf_dir, kf_write   core START and write port
//   err_clr, err_timeout     watchdog flag clear / sticky flag
//   busy                     high unless idle in LOAD with no word loaded
//   frame_cnt                completed frames, wraps at 2^16
module kf_frame_loader #(
  parameter int W     = 24,
  parameter int ADDRW = 5,
  parameter int NIN   = 2,
  parameter int BASE  = 0,
  parameter int TMO   = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  input  logic             kf_ready,
  input  logic [W-1:0]     kf_data_out,
  output logic             kf_start,
  output logic [W-1:0]     kf_data_in,
  output logic [ADDRW-1:0] kf_dir,
  output logic             kf_write,
  input  logic             err_clr,
  output logic             err_timeout,
  output logic             busy,
  output logic [15:0]      frame_cnt
);

  // Counter wide enough to hold TMO itself.
  localparam int CW = $clog2(TMO + 1);
  // Address arithmetic wraps naturally because everything is ADDRW bits wide.
  localparam logic [ADDRW-1:0] BASE_A   = ADDRW'(BASE);
  localparam logic [ADDRW-1:0] LAST_IDX = ADDRW'(NIN - 1);
  localparam logic [CW-1:0]    TMO_C    = CW'(TMO);

  typedef enum logic [2:0] {
    LOAD      = 3'd0,
    KICK      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    EMIT      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [ADDRW-1:0] idx_q, idx_d;
  logic [CW-1:0]    wd_q, wd_d;
  logic [CW-1:0]    wd_inc;
  logic             wd_hit;
  logic             kf_start_q, kf_start_d;
  logic             kf_write_q, kf_write_d;
  logic [ADDRW-1:0] kf_dir_q, kf_dir_d;
  logic [W-1:0]     kf_data_in_q, kf_data_in_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  // Watchdog fires on the cycle its count would reach TMO.
  assign wd_inc = wd_q + CW'(1'b1);
  assign wd_hit = (wd_inc == TMO_C);

  // No input buffering: accept only while loading and the core is ready.
  // Held low while reset is asserted so the stream sees no acceptance.
  assign in_ready = (state_q == LOAD) && kf_ready && !rst;

  assign kf_start    = kf_start_q;
  assign kf_write    = kf_write_q;
  assign kf_dir      = kf_dir_q;
  assign kf_data_in  = kf_data_in_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_timeout = err_q;
  assign busy        = busy_q;

  // Next-state, write-port, capture and watchdog decisions.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wd_d         = wd_q;
    kf_start_d   = 1'b0;
    kf_write_d   = 1'b0;
    kf_dir_d     = kf_dir_q;
    kf_data_in_d = kf_data_in_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    frame_cnt_d  = frame_cnt_q;
    busy_d       = busy_q;

    // A timeout below overrides this clear, so the set wins.
    if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      LOAD: begin
        if (in_valid && kf_ready) begin
          kf_write_d   = 1'b1;
          kf_data_in_d = in_data;
          kf_dir_d     = BASE_A + idx_q;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = KICK;
          end else begin
            idx_d = idx_q + ADDRW'(1'b1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      KICK: begin
        kf_start_d = 1'b1;
        wd_d       = '0;
        state_d    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        wd_d = wd_inc;
        if (wd_hit) begin
          err_d   = 1'b1;
          idx_d   = '0;
          state_d = LOAD;
        end else if (!kf_ready) begin
          state_d = WAIT_DONE;
        end else begin
          state_d = WAIT_BUSY;
        end
      end
      WAIT_DONE: begin
        wd_d = wd_inc;
        if (wd_hit) begin
          err_d   = 1'b1;
          idx_d   = '0;
          state_d = LOAD;
        end else if (kf_ready) begin
          out_data_d  = kf_data_out;
          out_valid_d = 1'b1;
          state_d     = EMIT;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = LOAD;
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = LOAD;
      end
    endcase

    if ((state_d == LOAD) && (idx_d == '0)) begin
      busy_d = 1'b0;
    end else begin
      busy_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      idx_q        <= '0;
      wd_q         <= '0;
      kf_start_q   <= 1'b0;
      kf_write_q   <= 1'b0;
      kf_dir_q     <= '0;
      kf_data_in_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_cnt_q  <= 16'd0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wd_q         <= wd_d;
      kf_start_q   <= kf_start_d;
      kf_write_q   <= kf_write_d;
      kf_dir_q     <= kf_dir_d;
      kf_data_in_q <= kf_data_in_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_cnt_q  <= frame_cnt_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_kf_frame_loader.sv
// Bench for kf_frame_loader. Two instances share every input: one with BASE=4
// and one with BASE=31 (address wrap). The bench plays both the host and the
// core, drives inputs on the falling edge and checks outputs there.
module tb_kf_frame_loader;
  localparam int W      = 24;
  localparam int ADDRW  = 5;
  localparam int NIN    = 2;
  localparam int TMO    = 16;
  localparam int BASE_A = 4;
  localparam int BASE_B = 31;
  localparam int DEPTH  = 1 << ADDRW;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready, kf_ready, err_clr;
  logic [W-1:0] in_data, kf_data_out;

  logic in_ready, out_valid, kf_start, kf_write, err_timeout, busy;
  logic [W-1:0] out_data, kf_data_in;
  logic [ADDRW-1:0] kf_dir;
  logic [15:0] frame_cnt;

  logic b_in_ready, b_out_valid, b_kf_start, b_kf_write, b_err_timeout, b_busy;
  logic [W-1:0] b_out_data, b_kf_data_in;
  logic [ADDRW-1:0] b_kf_dir;
  logic [15:0] b_frame_cnt;

  int total = 0;
  int bad = 0;
  int exp_frames = 0;
  bit exp_err = 1'b0;

  always #5 clk = ~clk;

  kf_frame_loader #(.W(W), .ADDRW(ADDRW), .NIN(NIN), .BASE(BASE_A), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .kf_ready(kf_ready), .kf_data_out(kf_data_out), .kf_start(kf_start),
    .kf_data_in(kf_data_in), .kf_dir(kf_dir), .kf_write(kf_write),
    .err_clr(err_clr), .err_timeout(err_timeout), .busy(busy), .frame_cnt(frame_cnt)
  );

  kf_frame_loader #(.W(W), .ADDRW(ADDRW), .NIN(NIN), .BASE(BASE_B), .TMO(TMO)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(out_ready),
    .kf_ready(kf_ready), .kf_data_out(kf_data_out), .kf_start(b_kf_start),
    .kf_data_in(b_kf_data_in), .kf_dir(b_kf_dir), .kf_write(b_kf_write),
    .err_clr(err_clr), .err_timeout(b_err_timeout), .busy(b_busy), .frame_cnt(b_frame_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset_vals();
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_data", 32'(out_data), 32'd0);
    check_val("rst_start", 32'(kf_start), 32'd0);
    check_val("rst_write", 32'(kf_write), 32'd0);
    check_val("rst_dir", 32'(kf_dir), 32'd0);
    check_val("rst_data_in", 32'(kf_data_in), 32'd0);
    check_val("rst_err", 32'(err_timeout), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_fcnt", 32'(frame_cnt), 32'd0);
    check_val("rst_b_in_ready", 32'(b_in_ready), 32'd0);
    check_val("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    check_val("rst_b_out_data", 32'(b_out_data), 32'd0);
    check_val("rst_b_start", 32'(b_kf_start), 32'd0);
    check_val("rst_b_write", 32'(b_kf_write), 32'd0);
    check_val("rst_b_dir", 32'(b_kf_dir), 32'd0);
    check_val("rst_b_data_in", 32'(b_kf_data_in), 32'd0);
    check_val("rst_b_err", 32'(b_err_timeout), 32'd0);
    check_val("rst_b_busy", 32'(b_busy), 32'd0);
    check_val("rst_b_fcnt", 32'(b_frame_cnt), 32'd0);
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1; kf_ready = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    exp_frames = 0;
    exp_err = 1'b0;
  endtask

  task automatic check_write(input int k, input logic [W-1:0] word);
    check_val("wr", 32'(kf_write), 32'd1);
    check_val("dir", 32'(kf_dir), 32'((BASE_A + k) % DEPTH));
    check_val("data_in", 32'(kf_data_in), 32'(word));
    check_val("busy_load", 32'(busy), 32'd1);
    check_val("wr_b", 32'(b_kf_write), 32'd1);
    check_val("dir_b", 32'(b_kf_dir), 32'((BASE_B + k) % DEPTH));
    check_val("data_in_b", 32'(b_kf_data_in), 32'(word));
  endtask

  // mode 0: normal run, 1: core never finishes, 2: like 1 with err_clr held,
  // 3: reset while waiting for the core.
  task automatic run_frame(input int mode, input bit directed, input bit stall, input int emit_wait);
    logic [W-1:0] word;
    logic [W-1:0] est;
    int run_len;
    int idle;
    for (int k = 0; k < NIN; k++) begin
      if (directed) begin
        word = (k == 0) ? 24'h004000 : 24'h008000;
        idle = 0;
      end else begin
        word = W'($urandom());
        idle = int'($urandom_range(0, 2));
      end
      for (int i = 0; i < idle; i++) begin
        in_valid = 1'b0; kf_ready = 1'b1;
        tick();
        check_val("idle_wr", 32'(kf_write), 32'd0);
      end
      if (stall && (k > 0)) begin
        kf_ready = 1'b0; in_valid = 1'b1; in_data = ~word;
        for (int i = 0; i < 3; i++) begin
          #1;
          check_val("stall_in_ready", 32'(in_ready), 32'd0);
          tick();
          check_val("stall_wr", 32'(kf_write), 32'd0);
          check_val("stall_busy", 32'(busy), 32'd1);
        end
      end
      in_valid = 1'b1; in_data = word; kf_ready = 1'b1;
      #1;
      check_val("in_ready", 32'(in_ready), 32'd1);
      tick();
      check_write(k, word);
      in_valid = 1'b0;
    end

    tick();
    check_val("start", 32'(kf_start), 32'd1);
    check_val("wr_after_last", 32'(kf_write), 32'd0);
    tick();
    check_val("start_pulse", 32'(kf_start), 32'd0);
    kf_ready = 1'b0;
    err_clr = (mode == 2);

    if (mode == 0) begin
      run_len = directed ? 10 : int'($urandom_range(1, 10));
      for (int i = 0; i < run_len; i++) begin
        out_ready = (($urandom() % 2) == 1);
        tick();
        check_val("run_no_ov", 32'(out_valid), 32'd0);
        check_val("run_no_start", 32'(kf_start), 32'd0);
      end
      est = directed ? 24'h00C000 : W'($urandom());
      kf_data_out = est; kf_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_val("cap_ov", 32'(out_valid), 32'd1);
      check_val("cap_data", 32'(out_data), 32'(est));
      check_val("cap_ov_b", 32'(b_out_valid), 32'd1);
      check_val("cap_data_b", 32'(b_out_data), 32'(est));
      kf_data_out = ~est;
      for (int i = 0; i < emit_wait; i++) begin
        in_valid = 1'b1;
        #1;
        check_val("emit_in_ready", 32'(in_ready), 32'd0);
        tick();
        check_val("emit_ov", 32'(out_valid), 32'd1);
        check_val("emit_data", 32'(out_data), 32'(est));
        check_val("emit_wr", 32'(kf_write), 32'd0);
        check_val("emit_fcnt", 32'(frame_cnt), 32'(exp_frames % 65536));
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_frames++;
      check_val("hs_ov", 32'(out_valid), 32'd0);
      check_val("hs_fcnt", 32'(frame_cnt), 32'(exp_frames % 65536));
      check_val("hs_busy", 32'(busy), 32'd0);
      check_val("hs_fcnt_b", 32'(b_frame_cnt), 32'(exp_frames % 65536));
    end else if (mode == 3) begin
      repeat (3) tick();
      do_reset();
    end else begin
      // m counts falling edges since kf_start was first seen high.
      for (int m = 2; m <= TMO; m++) begin
        tick();
        check_val("to_no_ov", 32'(out_valid), 32'd0);
        if (m < TMO) begin
          check_val("to_err_early", 32'(err_timeout), (mode == 2) ? 32'd0 : 32'(exp_err));
        end else begin
          check_val("to_err_set", 32'(err_timeout), 32'd1);
          check_val("to_err_set_b", 32'(b_err_timeout), 32'd1);
        end
      end
      err_clr = 1'b0;
      exp_err = 1'b1;
      check_val("to_busy", 32'(busy), 32'd0);
      check_val("to_fcnt", 32'(frame_cnt), 32'(exp_frames % 65536));
    end
  endtask

  task automatic reset_mid_load();
    in_valid = 1'b1; kf_ready = 1'b1; in_data = W'($urandom());
    tick();
    check_val("ml_wr", 32'(kf_write), 32'd1);
    in_valid = 1'b0;
    do_reset();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    kf_ready = 1'b1; kf_data_out = '0; err_clr = 1'b0;
    tick();
    check_reset_vals();
    rst = 1'b0;
    tick();

    run_frame(0, 1'b1, 1'b0, 0);
    check_val("first_fcnt", 32'(frame_cnt), 32'd1);
    run_frame(0, 1'b0, 1'b0, 20);
    run_frame(0, 1'b0, 1'b1, 2);

    run_frame(1, 1'b0, 1'b0, 0);
    run_frame(0, 1'b0, 1'b0, 1);
    check_val("err_sticky", 32'(err_timeout), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err = 1'b0;
    check_val("err_cleared", 32'(err_timeout), 32'd0);

    run_frame(1, 1'b0, 1'b0, 0);
    run_frame(2, 1'b0, 1'b0, 0);
    run_frame(0, 1'b0, 1'b0, 0);

    reset_mid_load();
    run_frame(0, 1'b0, 1'b0, 1);
    run_frame(3, 1'b0, 1'b0, 0);
    run_frame(0, 1'b0, 1'b0, 0);

    for (int f = 0; f < 10; f++) begin
      run_frame(0, 1'b0, (($urandom() % 2) == 1), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kf_frame_loader.md
# kf_frame_loader

Upstream host-side stage for the Kalman filter core. It accepts measurement words on a valid/ready stream and writes them into consecutive data-bank addresses through the core's DATA_IN/DIR/WRITE port. It then pulses START, waits for the program run to complete (READY falls, then rises), captures DATA_OUT as the frame estimate and presents it on an output valid/ready stream. A watchdog aborts runs that never complete.

## Interface
- W, 24: data word width; matches core datapath (Q.14 fixed point, passed through unmodified).
- ADDRW, 5: data-bank address width.
- NIN, 2: measurement words per frame, range 1..2^ADDRW.
- BASE, 0: first data-bank address written per frame.
- TMO, 1023: watchdog limit in cycles for one run, at least 2.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  measurement word valid.
- in_data  in  W  measurement word.
- in_ready  out  1  loader accepts in_data this cycle.
- out_valid  out  1  estimate word valid.
- out_data  out  W  estimate word (captured core DATA_OUT).
- out_ready  in  1  downstream accepts out_data.
- kf_ready  in  1  core READY.
- kf_data_out  in  W  core DATA_OUT.
- kf_start  out  1  core START pulse.
- kf_data_in  out  W  core DATA_IN.
- kf_dir  out  ADDRW  core DIR.
- kf_write  out  1  core WRITE.
- err_clr  in  1  clears err_timeout.
- err_timeout  out  1  sticky watchdog flag.
- busy  out  1  high in any state other than LOAD with idx=0.
- frame_cnt  out  16  count of completed frames; wraps at 2^16.

## Operation
- States: LOAD, KICK, WAIT_BUSY, WAIT_DONE, EMIT.
- LOAD:
  - in_ready = kf_ready. No input buffering; in_ready is 0 in every other state.
  - On handshake (in_valid & in_ready): register kf_data_in = in_data, kf_dir = (BASE + idx) mod 2^ADDRW, kf_write = 1 for exactly one cycle. Then idx++.
  - After the NIN-th handshake: idx returns to 0 and the state goes to KICK.
- KICK: kf_start = 1 for one cycle; clear the watchdog counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - kf_ready = 0 moves to WAIT_DONE.
  - The watchdog counts every cycle from KICK+1.
- WAIT_DONE: on kf_ready = 1, capture kf_data_out into out_data, set out_valid = 1, go to EMIT.
- EMIT:
  - Hold out_data stable and out_valid = 1 until out_ready.
  - On the handshake: out_valid = 0, frame_cnt++, go to LOAD.
- Watchdog:
  - If the counter reaches TMO while in WAIT_BUSY or WAIT_DONE: err_timeout = 1, state goes to LOAD, idx = 0.
  - No output word is produced and frame_cnt is unchanged.
- err_clr clears err_timeout. If err_clr and a timeout occur in the same cycle, the set wins.
- Address wrap: BASE + idx is computed modulo 2^ADDRW.
- Data is never altered: no saturation, no sign handling.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, kf_start=0, kf_write=0, kf_dir=0, kf_data_in=0, err_timeout=0, busy=0, frame_cnt=0. State is LOAD, idx=0.
- All outputs are registered except in_ready, which is combinational from state and kf_ready.
- Write latency: kf_write is high in the cycle after the input handshake. Back-to-back inputs produce back-to-back writes.
- kf_start is asserted in the cycle after the last kf_write.
- Capture: out_valid rises in the cycle after kf_ready is sampled high in WAIT_DONE.
- Minimum frame period: NIN + 1 (KICK) + run + 1 (capture) + 1 (EMIT handshake) cycles.
- kf_ready falling during LOAD stalls acceptance. A partially loaded frame is retained, idx is kept, and no write is issued while kf_ready = 0.
- Reset mid-operation discards the partial frame. kf_start and kf_write drop asynchronously.
- out_ready held high before out_valid has no effect.

## Test plan
- NIN=2, BASE=4, continuous in_valid with words 0x004000 and 0x008000; core model drops READY 1 cycle after START and raises it 10 cycles later with DATA_OUT=0x00C000.
  - Required: writes to DIR 4 then 5 on consecutive cycles; one START pulse; out_data=0x00C000; frame_cnt=1.
- Backpressure: out_ready=0 for 20 cycles after out_valid.
  - Required: out_data is stable, in_ready=0 throughout, and a new frame loads only after the handshake.
- Wrap: BASE=31, NIN=2.
  - Required: writes go to DIR 31, then DIR 0.
- Watchdog: TMO=16, core keeps READY low forever.
  - Required: err_timeout=1 at 16 cycles after KICK; no out_valid; frame_cnt unchanged; next frame is accepted. err_clr pulse clears the flag, and err_clr coinciding with a timeout leaves the flag set.
- kf_ready=0 during LOAD after the first word.
  - Required: no kf_write and in_ready=0 while low; the second word goes to BASE+1 after READY returns.
- rst asserted in WAIT_DONE.
  - Required: all outputs return to reset values immediately; the next frame starts writing at BASE.
